// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution engine and its write-back stage.
package conv_pkg;

  localparam int H      = 32;
  localparam int W      = 16;
  localparam int ADDR_W = 16;

  typedef logic signed [W-1:0] data_t;

  typedef enum logic {IDLE, RUN} state_t;

  // Pooled (compacted) address of the 2x2 window holding input pixel (o, i)
  function automatic logic [ADDR_W-1:0] pool_addr(input logic [ADDR_W-1:0] o,
                                                  input logic [ADDR_W-1:0] i,
                                                  input int unsigned       h);
    logic [ADDR_W-1:0] half;
    half = ADDR_W'(h >> 1);
    return ((o >> 1) * half) + (i >> 1);
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-width line of partial column-pair maxima from the even row of each window pair.
module pool_linebuf #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int AW    = 4
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic signed [W-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic signed [W-1:0] rdata_o
);

  logic signed [W-1:0] mem_q [DEPTH];

  // Synchronous write; contents are never reset because every entry is written before use
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv2d_pool_wb.sv
// ReLU plus 2x2 stride-2 max-pool on the convolution engine output stream, written back
// with compacted addresses. Pooling is done on the fly using one half-width line buffer.
module conv2d_pool_wb #(
  parameter int H       = conv_pkg::H,
  parameter int W       = conv_pkg::W,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          start_i,
  input  logic                          in_valid_i,
  input  logic signed [W-1:0]           in_data_i,
  input  logic [conv_pkg::ADDR_W-1:0]   in_addr_i,
  output logic                          out_valid_o,
  output logic signed [W-1:0]           out_data_o,
  output logic [conv_pkg::ADDR_W-1:0]   out_addr_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);
  import conv_pkg::*;

  localparam int LG    = $clog2(H);
  localparam int IDX_W = (LG > 1) ? LG - 1 : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H * H - 1);

  function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] x);
    return (RELU_EN && x[W-1]) ? '0 : x;
  endfunction

  function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   exp_q, exp_d;
  logic                err_q, err_d;
  logic signed [W-1:0] pair_q, pair_d;
  logic                out_valid_q, out_valid_d;
  logic signed [W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                done_q, done_d;

  logic                accept;
  logic                lb_we;
  logic [ADDR_W-1:0]   i_idx, o_idx;
  logic [IDX_W-1:0]    lb_idx;
  logic signed [W-1:0] v, m, lb_rdata;

  // Decode the expected position and form the rectified sample and column-pair max
  always_comb begin
    i_idx  = exp_q & ADDR_W'(H - 1);
    o_idx  = exp_q >> LG;
    lb_idx = IDX_W'(i_idx >> 1);
    accept = (state_q == RUN) && in_valid_i && (in_addr_i == exp_q);
    v      = relu(in_data_i);
    m      = smax(pair_q, v);
    lb_we  = accept && i_idx[0] && !o_idx[0];
  end

  pool_linebuf #(
    .DEPTH (H / 2),
    .W     (W),
    .AW    (IDX_W)
  ) u_linebuf (
    .clk_i   (clk_i),
    .we_i    (lb_we),
    .waddr_i (lb_idx),
    .wdata_i (m),
    .raddr_i (lb_idx),
    .rdata_o (lb_rdata)
  );

  // Frame sequencing, address check, pooling decisions and output staging
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    err_d       = err_q;
    pair_d      = pair_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          exp_d   = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (in_valid_i && !accept) err_d = 1'b1;
        if (accept) begin
          exp_d = exp_q + 1'b1;
          if (!i_idx[0]) begin
            pair_d = v;
          end else if (o_idx[0]) begin
            out_valid_d = 1'b1;
            out_data_d  = smax(lb_rdata, m);
            out_addr_d  = pool_addr(o_idx, i_idx, 32'(H));
          end
          if (exp_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any frame in progress
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

  // Left-column holding register; always written before it is read
  always_ff @(posedge clk_i) begin
    pair_q <= pair_d;
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_addr_o  = out_addr_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/conv2d_pool_wb.md
Name: conv2d_pool_wb

Overview:
- Downstream stage of the 2-D convolution engine. Consumes its output-pixel stream: data word plus write address plus write strobe.
- Applies optional ReLU, then 2x2 max-pooling with stride 2, and emits pooled pixels with compacted write addresses to the output feature memory.
- Holds one half-width line of partial maxima, so pooling runs on the fly with no frame buffer.

Parameters:
- H, 32: input frame edge in pixels. Must be even and a power of two. Input addresses span 0..H*H-1.
- W, 16: data width. Data is signed two's complement.
- RELU_EN, 1: 1 clamps negative inputs to 0 before pooling; 0 passes inputs through.

Ports:
- clk_i  in  1  clock. All logic is on the rising edge.
- rstn_i  in  1  reset. Synchronous, active-low.
- start_i  in  1  begin a new frame. Sampled only in Idle.
- in_valid_i  in  1  input sample strobe (convolution engine write enable).
- in_data_i  in  W  input pixel, signed.
- in_addr_i  in  16  input pixel address. Low log2(H) bits are the inner index i (fastest varying); upper bits are the outer index o.
- out_valid_o  in/out: out  1  one-cycle strobe; a pooled pixel is valid.
- out_data_o  out  W  pooled pixel, signed.
- out_addr_o  out  16  pooled address = (o/2)*(H/2) + i/2.
- busy_o  out  1  high while in Run.
- done_o  out  1  one-cycle pulse when the frame completes.
- err_o  out  1  sticky sequence error. Cleared by an accepted start_i or by reset.

Behaviour:
- Reset (rstn_i low at a clock edge) forces: out_valid_o=0, out_data_o=0, out_addr_o=0, busy_o=0, done_o=0, err_o=0, state=Idle, expected address=0.
- Line buffer contents are not reset. Every entry is written before it is read.
- States:
  - Idle: start_i=1 -> Run. Also sets expected address exp=0 and clears err_o. in_valid_i is ignored in Idle, including in the same cycle as start_i.
  - Run: busy_o=1. start_i is ignored.
- Sample acceptance in Run:
  - A sample is accepted when in_valid_i=1 and in_addr_i==exp. exp then increments.
  - If in_valid_i=1 and in_addr_i!=exp: set err_o=1, drop the sample, leave exp unchanged, stay in Run.
  - Gaps (in_valid_i=0) are allowed and have no effect.
- Per accepted sample, let v = RELU_EN ? max(in_data_i, 0) : in_data_i, using a signed compare:
  - i even: pair_q <= v.
  - i odd: m = max(pair_q, v), signed.
    - o even: linebuf[i/2] <= m.
    - o odd: out_data_o <= max(linebuf[i/2], m), out_addr_o <= pooled address, out_valid_o <= 1 on the next cycle.
- Latency: out_valid_o is registered. It rises in the cycle after the accepting edge of the bottom-right sample of each 2x2 window. It pulses for one cycle only.
- No backpressure: the consumer must accept every out_valid_o pulse. Input rate is up to one sample per cycle; output rate is at most one per two cycles.
- Frame end: accepting exp==H*H-1 returns the block to Idle. done_o pulses in the same cycle as the final out_valid_o. busy_o falls in that same cycle.
- out_data_o and out_addr_o hold their last values between pulses.
- A start_i in the cycle after done_o begins the next frame. Back-to-back frames need no idle gap beyond that.
- A reset mid-frame aborts immediately. No partial output is emitted, and the next frame starts clean.
- Arithmetic: compares only, with no widening. Outputs are exactly W bits.
- Address width: 16 bits for all values of H up to 256. The pooled address fits in 2*log2(H)-2 bits and is zero-extended to 16.

Decomposition:
- Shared package conv_pkg holds:
  - the data type (W-bit signed);
  - constants H and ADDR_W=16;
  - the state enum {Idle, Run};
  - a function pool_addr(o, i) returning the pooled address.
  - The convolution engine uses the same package.
- Sub-module pool_linebuf: H/2 entries x W bits. One synchronous write port, one combinational read port, no reset. The top module holds the FSM, acceptance and sequence check, pair register, and output registers.

Test Plan:
- H=4, RELU_EN=1, start, then addresses 0..15 back-to-back with data=address:
  - pulses carry (addr,data) = (0,5), (1,7), (2,13), (3,15);
  - done_o coincides with the last pulse.
- H=4, RELU_EN=1, all data = -3 -> four pulses with data 0. With RELU_EN=0 the same stimulus -> four pulses with data -3.
- H=4, window values {-7, 2, -1, -9}, RELU_EN=0 -> pooled value 2. This checks the signed compare across both lines.
- H=4, sequence fault:
  - send address 0 then address 2 -> err_o=1; the sample at address 2 is dropped; no output pulse appears;
  - resume with 1..15 -> correct four pulses, and err_o stays 1;
  - the next start_i clears err_o.
- H=4, in_valid_i toggled 1-0-1 throughout the frame -> same four outputs as the first test; each pulse comes one cycle after its bottom-right sample.
- H=4, rstn_i low for one cycle after 9 samples:
  - all outputs are 0 and the block is in Idle;
  - the following full frame produces correct results, with no stale line-buffer influence.
